rvb_dispatch: RTL
=================

RVB_DISPATCH -- requirements
Module: rvb_dispatch

Interface
REQ-001 Parameter XLEN, default 64: datapath width, 32 or 64.
REQ-002 Parameter TAGW, default 5: destination-tag width.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 issue_valid/issue_ready  in/out  1  core-side request handshake.
REQ-006 issue_insn  in  32  raw instruction word.
REQ-007 issue_rs1, issue_rs2, issue_rs3  in  XLEN  operand values.
REQ-008 issue_tag  in  TAGW  destination tag.
REQ-009 unit_din_valid/unit_din_ready  out/in  1  shifter-unit input handshake.
REQ-010 unit_rs1, unit_rs2, unit_rs3  out  XLEN  unit operands.
REQ-011 unit_insn3, unit_insn14, unit_insn26, unit_insn27, unit_insn29, unit_insn30  out  1 each  unit decode bits.
REQ-012 unit_dout_valid/unit_dout_ready  in/out  1  unit result handshake.
REQ-013 unit_dout_rd  in  XLEN  unit result.
REQ-014 wb_valid/wb_ready  out/in  1  writeback handshake.
REQ-015 wb_rd  out  XLEN, wb_tag  out  TAGW  writeback result and tag.
REQ-016 busy  out  1  high while any request, in-flight tag, or wb result is held.

Function
REQ-017 A transfer occurs on any handshake only in a cycle where valid and ready are both high.
REQ-018 An accepted issue SHALL be registered: unit_insnN = issue_insn[N]; unit_rs1/unit_rs3 = issue_rs1/issue_rs3.
REQ-019 unit_rs2 SHALL be issue_rs2 when issue_insn[5]=1, else zero-extended issue_insn[25:20].
REQ-020 unit_din_valid SHALL be high exactly while the request stage holds an entry; outputs are held stable until the transfer.
REQ-021 On each unit input transfer the request's tag SHALL be pushed into a 4-entry in-order tag FIFO.
REQ-022 unit_din_valid SHALL be forced low while the tag FIFO is full.
REQ-023 unit_dout_ready SHALL be (tag FIFO not empty) AND (!wb_valid OR wb_ready).
REQ-024 On a result transfer, wb_rd <= unit_dout_rd, wb_tag <= FIFO head, wb_valid <= 1, head popped, all in the same edge.
REQ-025 wb_valid clears on a wb transfer unless a new result is captured in the same cycle.
REQ-026 A push and a pop of the tag FIFO in the same cycle SHALL keep the count unchanged; full/empty are registered flags.
REQ-027 A unit whose dout_valid asserts combinationally in the same cycle as din_valid SHALL complete the op in one cycle, writing back one cycle after the din transfer.
REQ-028 Minimum latency is 3 clock edges from issue acceptance to wb_valid high (with a zero-latency unit): request register, unit transfer, result capture.
REQ-029 unit_dout_valid while the tag FIFO is empty is a protocol error; it SHALL be ignored (no capture, no pop).

Reset
REQ-030 On resetn low: issue_ready=0 while asserted; unit_din_valid=0; unit_dout_ready=0; wb_valid=0; busy=0; FIFO empty; all data/tag registers 0.
REQ-031 Reset mid-operation SHALL discard all in-flight requests and results without emitting a writeback.

Configuration
REQ-032 Macro RVB_DISPATCH_SKID_EN defined: the request stage is a 2-entry skid buffer; issue_ready = !(second entry valid), registered; sustained throughput is one op per cycle.
REQ-033 Macro RVB_DISPATCH_SKID_EN undefined: single-entry request stage; issue_ready = !(entry valid), registered; maximum throughput is one op per two cycles.

Structure
REQ-034 The shared package SHALL hold the request struct typedef (operands, decode bits, tag), the tag FIFO depth constant (4), and the OP-IMM select bit index (5).
REQ-035 The tag FIFO SHALL be one sub-module, rvb_dispatch_tagfifo, parameterised by TAGW and depth.

Verification
REQ-036 Single op: issue insn=0x40005033, rs1=0xF0, rs2=4, tag=3, with a zero-latency SRA model -> wb_rd=0x0F, wb_tag=3, 3 edges after issue acceptance.
REQ-037 OP-IMM: issue insn with [5]=0 and [25:20]=6'h21, rs2=0xFFFF -> unit_rs2=0x21.
REQ-038 Backpressure: wb_ready=0 with a zero-latency unit, issue 6 ops (tags 0-5) -> the FIFO fills at 4, then issue_ready drops; release wb_ready -> tags 0-5 retire in order, none lost.
REQ-039 Throughput: unit and wb always ready, 10 back-to-back issues -> 10 writebacks in 10 cycles with the macro defined, 20 cycles without.
REQ-040 Reset with 2 ops in flight -> all valids low, no writebacks; a post-reset op with tag=7 returns tag 7.
REQ-041 Spurious unit_dout_valid with the FIFO empty -> wb_valid stays 0 and the FIFO count stays 0.

Source files
------------

// File: rtl/rvb_dispatch_pkg.sv
// Shared types and constants for the rvb_dispatch shifter-unit dispatcher.
// The request struct is sized for the widest supported build (XLEN<=64, TAGW<=8).
package rvb_dispatch_pkg;

    localparam int TAG_FIFO_DEPTH = 4;
    localparam int OPIMM_SEL_BIT  = 5;
    localparam int REQ_XLEN_MAX   = 64;
    localparam int REQ_TAGW_MAX   = 8;

    typedef struct packed {
        logic [REQ_XLEN_MAX-1:0] rs1;
        logic [REQ_XLEN_MAX-1:0] rs2;
        logic [REQ_XLEN_MAX-1:0] rs3;
        logic                    insn3;
        logic                    insn14;
        logic                    insn26;
        logic                    insn27;
        logic                    insn29;
        logic                    insn30;
        logic [REQ_TAGW_MAX-1:0] tag;
    } req_t;

endpackage

// File: rtl/rvb_dispatch_tagfifo.sv
// In-order destination-tag FIFO with registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module rvb_dispatch_tagfifo
    import rvb_dispatch_pkg::*;
#(
    parameter int TAGW  = 5,
    parameter int DEPTH = TAG_FIFO_DEPTH
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            push,
    input  logic [TAGW-1:0] push_tag,
    input  logic            pop,
    output logic [TAGW-1:0] head,
    output logic            full,
    output logic            empty
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [TAGW-1:0] mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNTW'(1);
        end else if (pop && !push) begin
            count_next = count - CNTW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            count <= count_next;
            full  <= (count_next == CNTW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rvb_dispatch.sv
// Dispatcher between a core issue port and a shifter unit, with in-order tag tracking.
// Define RVB_DISPATCH_SKID_EN for a 2-entry skid request stage (one op per cycle).
module rvb_dispatch
    import rvb_dispatch_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [31:0]     issue_insn,
    input  logic [XLEN-1:0] issue_rs1,
    input  logic [XLEN-1:0] issue_rs2,
    input  logic [XLEN-1:0] issue_rs3,
    input  logic [TAGW-1:0] issue_tag,
    output logic            unit_din_valid,
    input  logic            unit_din_ready,
    output logic [XLEN-1:0] unit_rs1,
    output logic [XLEN-1:0] unit_rs2,
    output logic [XLEN-1:0] unit_rs3,
    output logic            unit_insn3,
    output logic            unit_insn14,
    output logic            unit_insn26,
    output logic            unit_insn27,
    output logic            unit_insn29,
    output logic            unit_insn30,
    input  logic            unit_dout_valid,
    output logic            unit_dout_ready,
    input  logic [XLEN-1:0] unit_dout_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_rd,
    output logic [TAGW-1:0] wb_tag,
    output logic            busy
);

    req_t            req_new;
    req_t            ent0_q;
    req_t            ent0_d;
    logic            ent0_valid_q;
    logic            ent0_valid_d;
`ifdef RVB_DISPATCH_SKID_EN
    req_t            ent1_q;
    req_t            ent1_d;
    logic            ent1_valid_q;
    logic            ent1_valid_d;
`endif
    logic            ready_q;
    logic            ready_d;
    logic            issue_fire;
    logic            din_fire;
    logic            res_fire;
    logic            fifo_full;
    logic            fifo_empty;
    logic [TAGW-1:0] fifo_head;
    logic            spare_unused;

    // Instruction bits the unit does not decode are dropped on purpose.
    assign spare_unused = ^{issue_insn, ent0_q};

    always_comb begin
        req_new                 = '0;
        req_new.rs1[XLEN-1:0]   = issue_rs1;
        req_new.rs3[XLEN-1:0]   = issue_rs3;
        if (issue_insn[OPIMM_SEL_BIT]) begin
            req_new.rs2[XLEN-1:0] = issue_rs2;
        end else begin
            req_new.rs2[5:0]      = issue_insn[25:20];
        end
        req_new.insn3           = issue_insn[3];
        req_new.insn14          = issue_insn[14];
        req_new.insn26          = issue_insn[26];
        req_new.insn27          = issue_insn[27];
        req_new.insn29          = issue_insn[29];
        req_new.insn30          = issue_insn[30];
        req_new.tag[TAGW-1:0]   = issue_tag;
    end

    assign issue_ready    = ready_q;
    assign issue_fire     = issue_valid & ready_q;
    assign unit_din_valid = ent0_valid_q & ~fifo_full;
    assign din_fire       = unit_din_valid & unit_din_ready;

    always_comb begin
        ent0_valid_d = ent0_valid_q;
        ent0_d       = ent0_q;
`ifdef RVB_DISPATCH_SKID_EN
        ent1_valid_d = ent1_valid_q;
        ent1_d       = ent1_q;
        if (din_fire) begin
            ent0_valid_d = ent1_valid_q;
            ent0_d       = ent1_q;
            ent1_valid_d = 1'b0;
        end
        if (issue_fire) begin
            if (!ent0_valid_d) begin
                ent0_valid_d = 1'b1;
                ent0_d       = req_new;
            end else begin
                ent1_valid_d = 1'b1;
                ent1_d       = req_new;
            end
        end
        ready_d = ~ent1_valid_d;
`else
        if (din_fire) begin
            ent0_valid_d = 1'b0;
        end
        if (issue_fire) begin
            ent0_valid_d = 1'b1;
            ent0_d       = req_new;
        end
        ready_d = ~ent0_valid_d;
`endif
    end

    // issue_ready is its own flop so it reads low throughout reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ent0_q       <= '0;
            ent0_valid_q <= 1'b0;
`ifdef RVB_DISPATCH_SKID_EN
            ent1_q       <= '0;
            ent1_valid_q <= 1'b0;
`endif
            ready_q      <= 1'b0;
        end else begin
            ent0_q       <= ent0_d;
            ent0_valid_q <= ent0_valid_d;
`ifdef RVB_DISPATCH_SKID_EN
            ent1_q       <= ent1_d;
            ent1_valid_q <= ent1_valid_d;
`endif
            ready_q      <= ready_d;
        end
    end

    assign unit_rs1    = ent0_q.rs1[XLEN-1:0];
    assign unit_rs2    = ent0_q.rs2[XLEN-1:0];
    assign unit_rs3    = ent0_q.rs3[XLEN-1:0];
    assign unit_insn3  = ent0_q.insn3;
    assign unit_insn14 = ent0_q.insn14;
    assign unit_insn26 = ent0_q.insn26;
    assign unit_insn27 = ent0_q.insn27;
    assign unit_insn29 = ent0_q.insn29;
    assign unit_insn30 = ent0_q.insn30;

    rvb_dispatch_tagfifo #(
        .TAGW  (TAGW),
        .DEPTH (TAG_FIFO_DEPTH)
    ) u_tagfifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (din_fire),
        .push_tag (ent0_q.tag[TAGW-1:0]),
        .pop      (res_fire),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // An empty FIFO keeps dout_ready low, so a stray unit result is never taken.
    assign unit_dout_ready = ~fifo_empty & (~wb_valid | wb_ready);
    assign res_fire        = unit_dout_valid & unit_dout_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_tag   <= '0;
        end else if (res_fire) begin
            wb_valid <= 1'b1;
            wb_rd    <= unit_dout_rd;
            wb_tag   <= fifo_head;
        end else if (wb_valid && wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    assign busy = ent0_valid_q | ~fifo_empty | wb_valid;

endmodule
